// File: rtl/irq_cond_pkg.sv
// Shared types and register offsets for the APB interrupt-line conditioner.
package irq_cond_pkg;

    typedef enum logic [1:0] {
        IRQ_LEVEL = 2'b00,
        IRQ_RISE  = 2'b01,
        IRQ_FALL  = 2'b10,
        IRQ_BOTH  = 2'b11
    } irq_mode_e;

    localparam logic [4:0] REG_MODE_LO = 5'h00;
    localparam logic [4:0] REG_MODE_HI = 5'h04;
    localparam logic [4:0] REG_PENDING = 5'h08;
    localparam logic [4:0] REG_MASK    = 5'h0C;
    localparam logic [4:0] REG_RAW     = 5'h10;
    localparam logic [4:0] REG_FILTER  = 5'h14;

endpackage

// File: rtl/irq_line_cond.sv
// One request line: 2-flop synchroniser, debounce filter, edge detect and sticky pending bit.
module irq_line_cond
    import irq_cond_pkg::*;
#(
    parameter int unsigned FILT_W = 4
) (
    input  logic              clk_i,
    input  logic              HRESETn,
    input  logic              src,
    input  irq_mode_e         mode,
    input  logic [FILT_W-1:0] filter,
    input  logic              clr,
    input  logic              mask,
    output logic              raw,
    output logic              filt,
    output logic              pending,
    output logic              irq
);

    logic              ff1_q, ff2_q;
    logic              filt_q, filt_d, filt_dly_q;
    logic              pend_q, pend_d;
    logic              rise, fall, edge_hit;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            ff1_q      <= 1'b0;
            ff2_q      <= 1'b0;
            cnt_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            ff1_q      <= src;
            ff2_q      <= ff1_q;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            pend_q     <= pend_d;
        end
    end

    // Any sample agreeing with the filtered level restarts the debounce count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (ff2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == filter) begin
            filt_d = ff2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;

    // A new edge beats a simultaneous software clear.
    always_comb begin
        edge_hit = 1'b0;
        unique case (mode)
            IRQ_LEVEL: edge_hit = 1'b0;
            IRQ_RISE:  edge_hit = rise;
            IRQ_FALL:  edge_hit = fall;
            IRQ_BOTH:  edge_hit = rise | fall;
        endcase
        pend_d = edge_hit | (pend_q & ~clr);
    end

    assign raw     = ff2_q;
    assign filt    = filt_q;
    assign pending = (mode == IRQ_LEVEL) ? filt_q : pend_q;
    assign irq     = mask & pending;

endmodule

// File: rtl/apb_irq_conditioner.sv
// APB-programmable conditioner: per-line sync/debounce/edge logic plus MODE, MASK, FILTER regs.
module apb_irq_conditioner
    import irq_cond_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned N_LINES        = 32,
    parameter int unsigned FILT_W         = 4
) (
    input  logic                      clk_i,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_LINES-1:0]        src_i,
    output logic [N_LINES-1:0]        irq_o
);

    logic [4:0]           reg_off;
    logic                 wr_en;
    logic [2*N_LINES-1:0] mode_q, mode_d;
    logic [N_LINES-1:0]   mask_q, mask_d;
    logic [FILT_W-1:0]    filter_q, filter_d;
    logic [N_LINES-1:0]   clr, raw, filt, pending;
    logic                 unused_bits;

    assign reg_off     = {PADDR[4:2], 2'b00};
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign PREADY      = 1'b1;
    assign PSLVERR     = PSEL & (PADDR[4:2] > 3'd5);
    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], filt, PWDATA};

    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_q   <= '0;
            mask_q   <= '0;
            filter_q <= '0;
        end else begin
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            filter_q <= filter_d;
        end
    end

    // Lines 16+ live in MODE_HI; the i%16 keeps the word index in range for every line.
    always_comb begin
        mode_d   = mode_q;
        mask_d   = mask_q;
        filter_d = filter_q;
        clr      = '0;
        if (wr_en) begin
            case (reg_off)
                REG_MODE_LO: begin
                    for (int i = 0; i < N_LINES; i++) begin
                        if (i < 16) mode_d[2*i +: 2] = PWDATA[2*(i%16) +: 2];
                    end
                end
                REG_MODE_HI: begin
                    for (int i = 0; i < N_LINES; i++) begin
                        if (i >= 16) mode_d[2*i +: 2] = PWDATA[2*(i%16) +: 2];
                    end
                end
                REG_PENDING: clr      = PWDATA[N_LINES-1:0];
                REG_MASK:    mask_d   = PWDATA[N_LINES-1:0];
                REG_FILTER:  filter_d = PWDATA[FILT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (reg_off)
                REG_MODE_LO: begin
                    for (int i = 0; i < N_LINES; i++) begin
                        if (i < 16) PRDATA[2*(i%16) +: 2] = mode_q[2*i +: 2];
                    end
                end
                REG_MODE_HI: begin
                    for (int i = 0; i < N_LINES; i++) begin
                        if (i >= 16) PRDATA[2*(i%16) +: 2] = mode_q[2*i +: 2];
                    end
                end
                REG_PENDING: PRDATA[N_LINES-1:0] = pending;
                REG_MASK:    PRDATA[N_LINES-1:0] = mask_q;
                REG_RAW:     PRDATA[N_LINES-1:0] = raw;
                REG_FILTER:  PRDATA[FILT_W-1:0]  = filter_q;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        irq_line_cond #(
            .FILT_W(FILT_W)
        ) u_line (
            .clk_i   (clk_i),
            .HRESETn (HRESETn),
            .src     (src_i[g]),
            .mode    (irq_mode_e'(mode_q[2*g +: 2])),
            .filter  (filter_q),
            .clr     (clr[g]),
            .mask    (mask_q[g]),
            .raw     (raw[g]),
            .filt    (filt[g]),
            .pending (pending[g]),
            .irq     (irq_o[g])
        );
    end

endmodule

// File: tb/tb_apb_irq_conditioner.sv
// Scoreboard bench: driver feeds a windowed-history reference model, monitor compares per cycle.
module tb_apb_irq_conditioner;

    localparam int unsigned AW = 12;
    localparam int unsigned NL = 32;
    localparam int unsigned FW = 4;

    logic          clk_i = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic          PWRITE = 1'b0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [NL-1:0] src_i = '0;
    logic [NL-1:0] irq_o;

    always #5 clk_i = ~clk_i;

    apb_irq_conditioner #(
        .APB_ADDR_WIDTH(AW),
        .N_LINES       (NL),
        .FILT_W        (FW)
    ) dut (
        .clk_i   (clk_i),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .src_i   (src_i),
        .irq_o   (irq_o)
    );

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } rd_exp_t;

    logic [NL-1:0] irq_q[$];
    rd_exp_t       rd_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: filt flips once the last FILTER+1 synchronised samples all disagree with it.
    bit [1:0]    m_mode[NL];
    bit [NL-1:0] m_mask, m_filt, m_filt_prev, m_pend;
    int          m_flt;
    bit [NL-1:0] samp[$];
    logic [NL-1:0] src_drv = '0;
    bit          rand_src = 1'b0;
    int          tog_div = 4;

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) m_mode[i] = 2'd0;
        m_mask = '0; m_filt = '0; m_filt_prev = '0; m_pend = '0; m_flt = 0;
        samp.delete();
        repeat (20) samp.push_back('0);
    endfunction

    function automatic logic [NL-1:0] model_irq();
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++)
            r[i] = m_mask[i] & ((m_mode[i] == 2'd0) ? m_filt[i] : m_pend[i]);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        logic [31:0] r;
        r = '0;
        case (a[4:2])
            3'd0: for (int i = 0; i < 16; i++) r[2*i +: 2] = m_mode[i];
            3'd1: for (int i = 0; i < 16; i++) r[2*i +: 2] = m_mode[16+i];
            3'd2: for (int i = 0; i < NL; i++)
                      r[i] = (m_mode[i] == 2'd0) ? m_filt[i] : m_pend[i];
            3'd3: r = m_mask;
            3'd4: r = samp[samp.size()-2];
            3'd5: r = 32'(m_flt);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void model_step(input logic [NL-1:0] src, input bit wr,
                                       input logic [AW-1:0] a, input logic [31:0] wd);
        bit [NL-1:0] nf, sel, clr;
        int n;
        bit v, all, rise, fall;
        n   = samp.size();
        clr = (wr && a[4:2] == 3'd2) ? wd[NL-1:0] : '0;
        nf  = m_filt;
        sel = '0;
        for (int i = 0; i < NL; i++) begin
            v   = samp[n-2][i];
            all = 1'b1;
            for (int j = 0; j <= m_flt; j++) if (samp[n-2-j][i] != v) all = 1'b0;
            if (all && v != m_filt[i]) nf[i] = v;
            rise = m_filt[i] & ~m_filt_prev[i];
            fall = ~m_filt[i] & m_filt_prev[i];
            case (m_mode[i])
                2'd1: sel[i] = rise;
                2'd2: sel[i] = fall;
                2'd3: sel[i] = rise | fall;
                default: sel[i] = 1'b0;
            endcase
        end
        m_pend      = sel | (m_pend & ~clr);
        m_filt_prev = m_filt;
        m_filt      = nf;
        samp.push_back(src);
        if (samp.size() > 40) void'(samp.pop_front());
        if (wr) begin
            case (a[4:2])
                3'd0: for (int i = 0; i < 16; i++) m_mode[i] = wd[2*i +: 2];
                3'd1: for (int i = 0; i < 16; i++) m_mode[16+i] = wd[2*i +: 2];
                3'd3: m_mask = wd[NL-1:0];
                3'd5: m_flt = int'(wd[FW-1:0]);
                default: ;
            endcase
        end
    endfunction

    task automatic cycle(input bit rst, input bit sel, input bit en, input bit wr,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        @(negedge clk_i);
        #1;
        if (rand_src)
            for (int i = 0; i < NL; i++)
                if ($urandom_range(tog_div - 1) == 0) src_drv[i] = ~src_drv[i];
        HRESETn = rst;
        PSEL    = sel;
        PENABLE = en;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        src_i   = src_drv;
        if (!rst) model_reset();
        irq_q.push_back(model_irq());
        if (sel && en && !wr) rd_q.push_back('{data: model_read(a), addr: a});
        if (rst) model_step(src_drv, sel && en && wr, a, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, a, d);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic apb_read(input logic [AW-1:0] a);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, a, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, a, '0);
    endtask

    task automatic run_random(input int seg);
        int unsigned   k;
        logic [AW-1:0] a;
        for (int op = 0; op < 25; op++) begin
            k = $urandom_range(9);
            a = AW'($urandom);
            a[1:0] = 2'b00;
            if (k < 3) begin
                idle(1 + int'($urandom_range(2)));
            end else if (k < 5) begin
                apb_read(a);
            end else if (k < 8) begin
                if (a[4:2] == 3'd5) a[4:2] = 3'd3;
                apb_write(a, $urandom);
            end else if (k == 8) begin
                apb_write(12'h008, $urandom);
            end else if (seg % 3 == 2 && $urandom_range(3) == 0) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
                cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            end else begin
                apb_read(12'h008);
            end
        end
    endtask

    // Monitor samples mid-low-phase: outputs reflect the previous edge, inputs already set.
    initial begin
        logic [NL-1:0] exp_irq;
        rd_exp_t       e;
        forever begin
            @(negedge clk_i);
            #3;
            if (irq_q.size() > 0) begin
                exp_irq = irq_q.pop_front();
                checks++;
                if (irq_o !== exp_irq) begin
                    errors++;
                    $display("FAIL irq_o @%0t: got %h expected %h", $time, irq_o, exp_irq);
                end
            end
            if (PSEL && PENABLE) begin
                checks++;
                if (PSLVERR !== (PADDR[4:2] > 3'd5) || PREADY !== 1'b1) begin
                    errors++;
                    $display("FAIL pslverr/pready @%0t addr %h: got %b/%b expected %b/1",
                             $time, PADDR, PSLVERR, PREADY, PADDR[4:2] > 3'd5);
                end
            end
            if (PSEL && PENABLE && !PWRITE) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read @%0t: no expected entry for addr %h", $time, PADDR);
                end else begin
                    e = rd_q.pop_front();
                    if (PRDATA !== e.data) begin
                        errors++;
                        $display("FAIL prdata @%0t addr %h: got %h expected %h",
                                 $time, e.addr, PRDATA, e.data);
                    end
                end
            end
            if (!PSEL) begin
                checks++;
                if (PRDATA !== 32'h0) begin
                    errors++;
                    $display("FAIL prdata_idle @%0t: got %h expected 0", $time, PRDATA);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        apb_read(12'h000);
        apb_read(12'h008);
        apb_read(12'h00C);
        apb_read(12'h014);

        // Level mode, line 0.
        apb_write(12'h00C, 32'h1);
        idle(2);
        src_drv[0] = 1'b1; idle(5);
        src_drv[0] = 1'b0; idle(5);

        // Rising-edge line 5, then W1C.
        apb_write(12'h000, 32'h400);
        apb_write(12'h00C, 32'h21);
        src_drv[5] = 1'b1; idle(2);
        src_drv[5] = 1'b0; idle(4);
        apb_read(12'h008);
        apb_write(12'h008, 32'h20);
        idle(2);

        // Debounce with FILTER=3 on line 2.
        apb_write(12'h00C, 32'h25);
        apb_write(12'h014, 32'h3);
        src_drv[2] = 1'b1; idle(3);
        src_drv[2] = 1'b0; idle(8);
        src_drv[2] = 1'b1; idle(2);
        apb_read(12'h010);
        src_drv[2] = 1'b0; idle(12);

        // Both-edge line 3: W1C lands on the edge that sets pending.
        apb_write(12'h014, 32'h0);
        apb_write(12'h000, 32'h4C0);
        apb_write(12'h00C, 32'h2D);
        src_drv[3] = 1'b1; idle(2);
        apb_write(12'h008, 32'h8);
        apb_read(12'h008);
        src_drv[3] = 1'b0; idle(2);
        apb_write(12'h008, 32'h8);
        apb_read(12'h008);
        idle(2);

        // Unmapped offsets.
        apb_read(12'h018);
        apb_write(12'h018, 32'hFFFF_FFFF);
        apb_write(12'h01C, 32'hFFFF_FFFF);
        for (int r = 0; r < 8; r++) apb_read(AW'(4 * r));

        // All lines pending with FILTER=7, then asynchronous reset.
        apb_write(12'h000, 32'hFFFF_FFFF);
        apb_write(12'h004, 32'hFFFF_FFFF);
        apb_write(12'h00C, 32'hFFFF_FFFF);
        src_drv = '1; idle(6);
        apb_write(12'h014, 32'h7);
        apb_read(12'h008);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h00C, '0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h00C, '0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h014, '0);
        apb_write(12'h00C, 32'hFFFF_FFFF);
        idle(4);
        apb_read(12'h008);

        // Randomised segments; FILTER only changes while the inputs are quiet.
        for (int seg = 0; seg < 12; seg++) begin
            rand_src = 1'b0;
            idle(20);
            apb_write(12'h014, 32'($urandom_range(4)));
            tog_div  = 2 + int'($urandom_range(6));
            rand_src = 1'b1;
            run_random(seg);
        end
        rand_src = 1'b0;
        idle(3);

        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL read_queue: %0d entries left, expected 0", rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
